// File: rtl/video_output_stage.sv
// -----------------------------------------------------------------------------
// video_output_stage
//
// Final registered stage of the colour-bar video path. It takes the pattern
// stage's beam signals and drives the pins. Pixel data and syncs go through two
// register stages, so every input reaches the outputs with equal latency.
// Blanking is enforced and a one-pixel safe-area border can be overlaid. A
// per-frame display mode (NORMAL / INVERT / MONO / BLACK) is applied to the
// pixel data.
//
// Ports
//   clk          in   pixel clock (only clock)
//   reset        in   synchronous, active-high
//   hsync_in     in   active-high hsync from the pattern stage
//   vsync_in     in   active-high vsync from the pattern stage
//   display_on   in   visible-area flag
//   hpos, vpos   in   beam column / row (9 bits)
//   rgb_in       in   {r,g,b} pixel
//   mode_next    in   request to advance the mode (level or pulse)
//   hsync        out  delayed hsync, polarity per SYNC_INVERT
//   vsync        out  delayed vsync, polarity per SYNC_INVERT
//   rgb          out  final pixel
//   mode         out  current mode: 0 NORMAL, 1 INVERT, 2 MONO, 3 BLACK
//   frame_start  out  one-cycle pulse on the first active cycle of output vsync
// -----------------------------------------------------------------------------
module video_output_stage #(
    parameter int FRAMES_PER_MODE = 60,   // 1..255
    parameter int AUTO_CYCLE      = 1,
    parameter int SYNC_INVERT     = 0,
    parameter int BORDER_EN       = 1,
    parameter int H_LAST          = 255,
    parameter int V_LAST          = 239
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic [2:0] rgb_in,
    input  logic       mode_next,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic [1:0] mode,
    output logic       frame_start
);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_MONO   = 2'd2,
        MODE_BLACK  = 2'd3
    } mode_e;

    localparam logic [8:0] H_LAST_C   = 9'(H_LAST);
    localparam logic [8:0] V_LAST_C   = 9'(V_LAST);
    localparam logic [7:0] FCNT_LAST  = 8'(FRAMES_PER_MODE - 1);
    localparam logic       SYNC_INV_C = (SYNC_INVERT != 0);
    localparam logic       AUTO_C     = (AUTO_CYCLE != 0);
    localparam logic       BORDER_C   = (BORDER_EN != 0);

    // ---------------- stage 1: registered input bundle ----------------
    logic       hs_s1_q, vs_s1_q, de_s1_q, bdr_s1_q;
    logic [2:0] rgb_s1_q;
    logic       bdr_d;

    // ---------------- stage 2: output registers ----------------
    // Syncs are held pre-inversion. vs_s2_q is also the "previous vsync"
    // for frame-edge detection. The polarity flip is a constant XOR on the pins.
    logic       hs_s2_q, vs_s2_q;
    logic [2:0] rgb_q, rgb_d;
    logic       fs_q;

    // ---------------- per-frame mode control ----------------
    mode_e      mode_q, mode_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       pending_q, pending_d;
    logic       fe, advance;

    // The border is only flagged on visible pixels, so blanking always wins.
    always_comb begin
        bdr_d = BORDER_C & display_on &
                ((hpos == 9'd0) || (hpos == H_LAST_C) ||
                 (vpos == 9'd0) || (vpos == V_LAST_C));
    end

    // The rising edge of stage-1 vsync marks the frame boundary. It always
    // falls in vertical blanking, so a mode switch here never splits a line.
    assign fe      = vs_s1_q & ~vs_s2_q;
    assign advance = fe & (pending_q | (AUTO_C & (fcnt_q == FCNT_LAST)));

    // The pixel transform uses the mode in force before this cycle's update.
    // The pixel leaving on a frame edge is in blanking anyway.
    always_comb begin
        rgb_d = rgb_s1_q;
        case (mode_q)
            MODE_NORMAL: rgb_d = rgb_s1_q;
            MODE_INVERT: rgb_d = ~rgb_s1_q;
            MODE_MONO:   rgb_d = (rgb_s1_q != 3'b000) ? 3'b111 : 3'b000;
            default:     rgb_d = 3'b000;
        endcase
        if (bdr_s1_q) rgb_d = 3'b111;
        if (!de_s1_q) rgb_d = 3'b000;
    end

    always_comb begin
        mode_d = advance ? mode_e'(mode_q + 2'd1) : mode_q;   // 3 wraps to 0

        fcnt_d = fcnt_q;
        if (!AUTO_C) begin
            fcnt_d = 8'd0;
        end else if (fe) begin
            fcnt_d = advance ? 8'd0 : fcnt_q + 8'd1;
        end

        // A request that arrives on the frame edge itself is kept for the
        // next frame, so it is never lost. Extra requests within a frame
        // collapse into one.
        pending_d = pending_q;
        if (mode_next) begin
            pending_d = 1'b1;
        end else if (fe) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_s1_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            de_s1_q   <= 1'b0;
            bdr_s1_q  <= 1'b0;
            rgb_s1_q  <= 3'b000;
            hs_s2_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            rgb_q     <= 3'b000;
            fs_q      <= 1'b0;
            mode_q    <= MODE_NORMAL;
            fcnt_q    <= 8'd0;
            pending_q <= 1'b0;
        end else begin
            hs_s1_q   <= hsync_in;
            vs_s1_q   <= vsync_in;
            de_s1_q   <= display_on;
            bdr_s1_q  <= bdr_d;
            rgb_s1_q  <= rgb_in;
            hs_s2_q   <= hs_s1_q;
            vs_s2_q   <= vs_s1_q;
            rgb_q     <= rgb_d;
            fs_q      <= fe;
            mode_q    <= mode_d;
            fcnt_q    <= fcnt_d;
            pending_q <= pending_d;
        end
    end

    assign hsync       = hs_s2_q ^ SYNC_INV_C;
    assign vsync       = vs_s2_q ^ SYNC_INV_C;
    assign rgb         = rgb_q;
    assign mode        = mode_q;
    assign frame_start = fs_q;

endmodule

// File: doc/video_output_stage.md
# video_output_stage

Final registered stage of the colour-bar video path. It sits directly downstream of the colour-bar pattern stage and consumes its `hsync`/`vsync`/`display_on`/`hpos`/`vpos`/`rgb` outputs. It drives the pins: pixel data and syncs are delayed through an equal-latency pipeline, blanking is enforced, and a per-frame display-mode state machine (normal, inverted, mono, black) is applied. An optional one-pixel white safe-area border is overlaid.

## Interface
- `FRAMES_PER_MODE`, default 60: frames per mode in auto-cycle; legal 1..255.
- `AUTO_CYCLE`, default 1: 1 = advance mode every `FRAMES_PER_MODE` frames; 0 = advance only on request.
- `SYNC_INVERT`, default 0: 1 = output syncs inverted (active-low).
- `BORDER_EN`, default 1: 1 = overlay white border at the visible-area edges.
- `H_LAST`, default 255: last visible column.
- `V_LAST`, default 239: last visible row.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `hsync_in`  in  1  active-high hsync from the pattern stage.
- `vsync_in`  in  1  active-high vsync from the pattern stage.
- `display_on`  in  1  visible-area flag.
- `hpos`  in  9  beam column.
- `vpos`  in  9  beam row.
- `rgb_in`  in  3  {r,g,b} pixel.
- `mode_next`  in  1  request to advance the mode; level or pulse; sampled every cycle.
- `hsync`  out  1  delayed hsync, polarity per `SYNC_INVERT`.
- `vsync`  out  1  delayed vsync, polarity per `SYNC_INVERT`.
- `rgb`  out  3  final pixel.
- `mode`  out  2  current mode: 0 NORMAL, 1 INVERT, 2 MONO, 3 BLACK.
- `frame_start`  out  1  one-cycle pulse on the first active cycle of output vsync.

## Operation
- **Stage 1** registers the input bundle: syncs, `display_on`, `rgb_in`, and a border flag.
  - The border flag is set when `BORDER_EN` is 1, `display_on` is 1, and (`hpos`==0, `hpos`==`H_LAST`, `vpos`==0 or `vpos`==`V_LAST`).
- **Stage 2** registers the outputs.
  - Transform of stage-1 rgb by mode:
    - NORMAL: rgb unchanged.
    - INVERT: `~rgb`.
    - MONO: 3'b111 if rgb!=0, else 3'b000.
    - BLACK: 3'b000.
  - Border overrides to 3'b111 in every mode, including BLACK.
  - Stage-1 `display_on`==0 forces 3'b000. This has priority over the border and every mode.
  - Syncs are XORed with `SYNC_INVERT` at stage 2.
- **Frame edge:** `fe = vsync_s1 & ~vsync_s2`, where `vsync_s2` is the stage-2 pre-inversion vsync.
- **Request latch:**
  - `pending` sets on any cycle with `mode_next`=1.
  - It clears on a cycle with `fe`=1, unless `mode_next` is also 1 on that cycle; then it stays set for the next frame.
- **Frame counter:** 8 bits, `fcnt`.
  - On `fe`: if advancing, `fcnt`←0; else `fcnt`←`fcnt`+1.
  - With `AUTO_CYCLE`=0, `fcnt` is held at 0.
- **Advance condition, evaluated only on `fe`:**
  - `pending` (the value before this cycle's update) is 1, or
  - `AUTO_CYCLE`=1 and `fcnt`==`FRAMES_PER_MODE`-1.
  - When both are true the mode advances once.
  - Advance: `mode`←`mode`+1, wrapping 3→0.
- Mode changes only on `fe`, which always falls in vertical blanking. No visible line ever mixes modes.
- `frame_start` is the registered `fe`.

## Timing
- Latency is exactly 2 clocks from every input (`hsync_in`, `vsync_in`, `display_on`, `hpos`, `vpos`, `rgb_in`) to its effect on `hsync`/`vsync`/`rgb`. Relative alignment of hsync, vsync and rgb is preserved.
- `frame_start` and the new `mode` value appear in the same cycle as the first cycle of active output `vsync`.
- `mode_next` affects `mode` at the earliest on the next `fe` after it is sampled. Pulses arriving while `pending` is already set are not counted; at most one advance per frame.
- **Reset** (synchronous, any cycle, including mid-frame or mid-vsync):
  - All pipeline registers, `fcnt`, `pending` and `mode` clear to 0.
  - Outputs in the cycle after reset: `rgb`=0, `mode`=0, `frame_start`=0, `hsync`=`vsync`=`SYNC_INVERT`.
  - If `vsync_in` is high when reset releases, an `fe` occurs 2 cycles later and counts as a frame.
- `fcnt` never exceeds `FRAMES_PER_MODE`-1 in auto mode.
- With `FRAMES_PER_MODE`=1 the mode advances every frame.

## Test plan
- **Reset:** hold `reset` 3 cycles with `vsync_in`=1 mid-frame → `rgb`=0, `mode`=0, `frame_start`=0, syncs=0 (non-inverted). `frame_start`=1 exactly 2 cycles after release.
- **Latency/passthrough:** NORMAL, `BORDER_EN`=0, `display_on`=1, `rgb_in`=3'b101 at cycle N → `rgb`=3'b101 at N+2. `hsync_in` rising at N gives `hsync` rising at N+2.
- **Blanking:** `display_on`=0 with `rgb_in`=3'b111 in every mode, and with `hpos`=0 and `BORDER_EN`=1 → `rgb`=0 two cycles later.
- **Auto cycle:** `FRAMES_PER_MODE`=2 over 9 vsync pulses → `mode` sequence 0,1,1,2,2,3,3,0,0. Changes coincide with `frame_start`. INVERT maps 3'b110→3'b001; MONO maps 3'b010→3'b111.
- **Request:** `AUTO_CYCLE`=0; three `mode_next` pulses within one frame → exactly one advance at the next `fe`. A pulse coincident with an `fe` → no advance at that `fe`, one advance at the following `fe`.
- **Border/polarity:** `SYNC_INVERT`=1, mode BLACK, `hpos`=255, `vpos`=100, `display_on`=1 → `rgb`=3'b111. Interior pixel → 3'b000. `hsync` idles high and pulses low.
